// File: rtl/pipe_pkg.sv
// Shared types for the IF/MEM unified memory port arbiter.
// State and owner encodings plus latency counter width.
package pipe_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of MEM grants taken while a fetch waits.
// Clear has priority over increment.
module arb_starve_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != W'(MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported unified RAM shared by IF and MEM stages.
// MEM has priority; the starvation counter forces IF through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_pipe,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  import pipe_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t       state;
  owner_t           owner;
  logic             wr_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [SW-1:0]    starve_cnt;

  logic mem_req;
  logic idle;
  logic grant_mem;
  logic grant_if;
  logic starve_inc;
  logic starve_clr;

  assign mem_req   = mem_rd | mem_wr;
  assign idle      = (state == IDLE);
  assign grant_mem = idle && mem_req &&
                     (starve_cnt < SW'(STARVE_MAX) || !if_req);
  assign grant_if  = idle && if_req && !grant_mem;

  assign starve_inc = grant_mem && if_req;
  assign starve_clr = grant_if || (idle && !if_req);

  arb_starve_counter #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .cnt (starve_cnt)
  );

  assign stall_pipe = mem_req & ~mem_done;
  assign stall_if   = (if_req & ~if_done) | stall_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      wr_q      <= 1'b0;
      lat_cnt   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_mem || grant_if) begin
            owner    <= grant_mem ? OWN_MEM : OWN_IF;
            wr_q     <= grant_mem & mem_wr;
            ram_we   <= grant_mem & mem_wr;
            ram_addr <= grant_mem ? mem_addr : if_addr;
            if (grant_mem) ram_wdata <= mem_wdata;
            ram_en   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en  <= 1'b0;
          ram_we  <= 1'b0;
          lat_cnt <= LAT_W'(MEM_LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            if (owner == OWN_MEM) begin
              // stores leave the load data register untouched
              if (!wr_q) mem_rdata <= ram_rdata;
              mem_done <= 1'b1;
            end else begin
              if_rdata <= ram_rdata;
              if_done  <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DONE: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_wr_excl: assert property (
    @(posedge clk) disable iff (rst) !(mem_rd && mem_wr)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// transaction-level model of grants, latency and RAM contents.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          if_req, if_done, mem_rd, mem_wr, mem_done;
  logic [AW-1:0] if_addr, mem_addr, ram_addr;
  logic [DW-1:0] if_rdata, mem_wdata, mem_rdata, ram_wdata, ram_rdata;
  logic          stall_if, stall_pipe, ram_en, ram_we;

  logic          f_req, f_done, f_sif, f_spipe, f_en, f_we;
  logic [AW-1:0] f_addr, f_raddr;
  logic [DW-1:0] f_rdata, f_mrdata, f_wdata, f_ram_rdata;
  logic          f_mdone;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_pipe(stall_pipe),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)
  ) dut1 (
    .clk(clk), .rst(rst),
    .if_req(f_req), .if_addr(f_addr),
    .if_rdata(f_rdata), .if_done(f_done),
    .mem_rd(1'b0), .mem_wr(1'b0),
    .mem_addr('0), .mem_wdata('0),
    .mem_rdata(f_mrdata), .mem_done(f_mdone),
    .stall_if(f_sif), .stall_pipe(f_spipe),
    .ram_en(f_en), .ram_we(f_we),
    .ram_addr(f_raddr), .ram_wdata(f_wdata),
    .ram_rdata(f_ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'h8C22_0004;
    return 32'h1357_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // RAM model: data valid exactly MEM_LAT cycles after ram_en, X otherwise
  logic [DW-1:0] ram [0:255];
  bit            written [0:255];
  logic [DW-1:0] rp0, rp1, fp0;
  logic          rv0 = 1'b0, rv1 = 1'b0, fv0 = 1'b0;

  function automatic logic [DW-1:0] ram_word(input logic [7:0] i);
    return written[i] ? ram[i] : init_word(int'(i));
  endfunction

  always @(posedge clk) begin
    rv0 <= ram_en & ~ram_we;
    rp0 <= ram_word(ram_addr[9:2]);
    rv1 <= rv0;
    rp1 <= rp0;
    fv0 <= f_en & ~f_we;
    fp0 <= ram_word(f_raddr[9:2]);
    if (ram_en && ram_we) begin
      ram[ram_addr[9:2]]     <= ram_wdata;
      written[ram_addr[9:2]] <= 1'b1;
    end
  end

  assign ram_rdata   = rv1 ? rp1 : 'x;
  assign f_ram_rdata = fv0 ? fp0 : 'x;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] ref_mem [0:255];
  logic [AW-1:0] got [0:7];
  logic [AW-1:0] exp_ord [0:7];
  int            en_cyc [0:2];

  int            n, exp_issue, exp_done, busy_until, starve_m;
  bit            ifd_seen, md_seen, exp_own_mem, exp_we, mem_win;
  bit            exp_ifd, exp_md, w;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd, exp_data, exp_mrd;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_ord = '{32'h300, 32'h300, 32'h300, 32'h200,
                32'h300, 32'h300, 32'h300, 32'h200};

    rst = 1'b1;
    if_req = 0; if_addr = '0; mem_rd = 0; mem_wr = 0;
    mem_addr = '0; mem_wdata = '0; f_req = 0; f_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_stall_if", stall_if, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single fetch
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h40;
    for (int j = 0; j < 7; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        if (j == 5) if_req = 0;
      end
      @(negedge clk);
      chk("t1_ram_en", ram_en, j == 1);
      chk("t1_if_done", if_done, j == 4);
      chk("t1_stall_if", stall_if, j < 4);
      if (j == 1) begin
        chk("t1_ram_addr", ram_addr, 32'h40);
        chk("t1_ram_we", ram_we, 0);
      end
      if (j == 4) chk("t1_if_rdata", if_rdata, 32'h8C22_0004);
    end

    // store
    @(posedge clk); #1;
    mem_wr = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    for (int j = 0; j < 7; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        if (j == 5) mem_wr = 0;
      end
      @(negedge clk);
      chk("t2_ram_en", ram_en, j == 1);
      chk("t2_ram_we", ram_we, j == 1);
      chk("t2_mem_done", mem_done, j == 4);
      chk("t2_stall_pipe", stall_pipe, j < 4);
      if (j == 1) chk("t2_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
      if (j == 4) chk("t2_mem_rdata_hold", mem_rdata, 0);
    end
    chk("t2_ram_written", ram[64], 32'hDEAD_BEEF);
    ref_mem[64] = 32'hDEAD_BEEF;

    // load back the stored word
    @(posedge clk); #1;
    mem_rd = 1; mem_addr = 32'h100;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        if (j == 5) mem_rd = 0;
      end
      @(negedge clk);
      chk("t2r_mem_done", mem_done, j == 4);
      if (j == 4) chk("t2r_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
    end

    // both requesters held: starvation counter forces IF every 4th grant
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h200;
    mem_rd = 1; mem_addr = 32'h300;
    n = 0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      @(negedge clk);
      chk("t3_one_done", if_done & mem_done, 0);
      if (ram_en) begin
        got[n] = ram_addr;
        n++;
      end
      @(posedge clk); #1;
    end
    chk("t3_grants", n, 8);
    for (int i = 0; i < 8; i++) chk("t3_order", got[i], exp_ord[i]);
    if_req = 0; mem_rd = 0;
    repeat (8) @(posedge clk);
    #1;

    // MEM only, held: no starvation, fixed spacing
    mem_rd = 1; mem_addr = 32'h100;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (ram_en) begin
        en_cyc[n] = cyc;
        chk("t4_starve_zero", dut.starve_cnt, 0);
        n++;
      end
    end
    chk("t4_grants", n, 3);
    chk("t4_space_a", en_cyc[1] - en_cyc[0], LAT + 3);
    chk("t4_space_b", en_cyc[2] - en_cyc[1], LAT + 3);
    @(posedge clk); #1;
    mem_rd = 0;
    repeat (8) @(posedge clk);
    #1;

    // async reset during WAIT of a load
    mem_rd = 1; mem_addr = 32'h104;
    repeat (3) @(negedge clk);
    #2;
    rst = 1; mem_rd = 0;
    #1;
    chk("t5_ram_en", ram_en, 0);
    chk("t5_ram_we", ram_we, 0);
    chk("t5_ram_addr", ram_addr, 0);
    chk("t5_ram_wdata", ram_wdata, 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_mem_rdata", mem_rdata, 0);
    chk("t5_mem_done", mem_done, 0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (j == 1) rst = 0;
      @(negedge clk);
      chk("t5_no_done", mem_done, 0);
    end
    @(posedge clk); #1;
    mem_rd = 1; mem_addr = 32'h100;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        if (j == 5) mem_rd = 0;
      end
      @(negedge clk);
      chk("t5_re_done", mem_done, j == 4);
      if (j == 4) chk("t5_re_rdata", mem_rdata, 32'hDEAD_BEEF);
    end

    // MEM_LAT=1 instance fetch
    @(posedge clk); #1;
    f_req = 1; f_addr = 32'h44;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        if (j == 4) f_req = 0;
      end
      @(negedge clk);
      chk("t6_ram_en", f_en, j == 1);
      chk("t6_if_done", f_done, j == 3);
      if (j == 3) chk("t6_if_rdata", f_rdata, init_word(17));
    end

    // randomized traffic against a transaction-level model
    starve_m = 0; exp_issue = -10; exp_done = -10; busy_until = -10;
    ifd_seen = 0; md_seen = 0; exp_mrd = 32'hDEAD_BEEF;
    exp_own_mem = 0; exp_we = 0; exp_addr = '0; exp_wd = '0;
    exp_data = '0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (if_req && ifd_seen) begin
        if_req = 0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if ((mem_rd || mem_wr) && md_seen) begin
        mem_rd = 0; mem_wr = 0;
      end else if (!(mem_rd || mem_wr) && $urandom_range(0, 2) == 0) begin
        w = 1'($urandom_range(0, 1));
        mem_rd = !w; mem_wr = w;
        mem_addr = 32'($urandom_range(0, 63)) << 2;
        mem_wdata = $urandom;
      end
      @(negedge clk);
      ifd_seen = if_done;
      md_seen = mem_done;
      exp_ifd = (t == exp_done) && !exp_own_mem;
      exp_md = (t == exp_done) && exp_own_mem;
      chk("r_ram_en", ram_en, t == exp_issue);
      chk("r_if_done", if_done, exp_ifd);
      chk("r_mem_done", mem_done, exp_md);
      chk("r_stall_pipe", stall_pipe, (mem_rd || mem_wr) && !exp_md);
      chk("r_stall_if", stall_if,
          (if_req && !exp_ifd) || ((mem_rd || mem_wr) && !exp_md));
      if (t == exp_issue) begin
        chk("r_ram_addr", ram_addr, exp_addr);
        chk("r_ram_we", ram_we, exp_we);
        if (exp_we) chk("r_ram_wdata", ram_wdata, exp_wd);
      end
      if (exp_ifd) chk("r_if_rdata", if_rdata, exp_data);
      if (exp_md) begin
        chk("r_mem_rdata", mem_rdata, exp_we ? exp_mrd : exp_data);
        if (!exp_we) exp_mrd = exp_data;
      end
      if (t > busy_until && (if_req || mem_rd || mem_wr)) begin
        mem_win = (mem_rd || mem_wr) && (starve_m < SMAX || !if_req);
        if (mem_win && if_req)
          starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
        else
          starve_m = 0;
        exp_own_mem = mem_win;
        exp_issue = t + 1;
        exp_done = t + LAT + 2;
        busy_until = exp_done;
        exp_addr = mem_win ? mem_addr : if_addr;
        exp_we = mem_win && mem_wr;
        exp_wd = mem_wdata;
        if (exp_we) ref_mem[exp_addr[9:2]] = mem_wdata;
        else exp_data = ref_mem[exp_addr[9:2]];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined datapath.
- Sequences each access through a fixed-latency RAM and returns data with a done pulse.
- Generates the stall signals that the hazard logic ORs into PC/IF-ID write-disable and ID/EX bubble insertion.
- MEM normally has priority; a starvation counter guarantees IF progress.

Parameters:
- ADDR_W, 32, address width of requesters and RAM.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the ram_en cycle to valid ram_rdata; legal range 1..15, 0 illegal.
- STARVE_MAX, 3, consecutive MEM grants taken while if_req is pending before IF is forced; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request; held until if_done
- if_addr  input  ADDR_W  fetch address; stable while if_req is high
- if_rdata  output  DATA_W  fetched word; valid while if_done is high
- if_done  output  1  one-cycle fetch completion pulse
- mem_rd  input  1  load request; held until mem_done
- mem_wr  input  1  store request; held until mem_done
- mem_addr  input  ADDR_W  load/store address
- mem_wdata  input  DATA_W  store data
- mem_rdata  output  DATA_W  load data; valid while mem_done is high
- mem_done  output  1  one-cycle load/store completion pulse
- stall_if  output  1  freeze PC and IF/ID
- stall_pipe  output  1  freeze the whole pipeline (MEM access pending)
- ram_en  output  1  RAM access strobe, one cycle per access
- ram_we  output  1  RAM write enable, qualified by ram_en
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE, lat_cnt=0, starve_cnt=0; ram_en, ram_we, if_done, mem_done = 0; ram_addr, ram_wdata, if_rdata, mem_rdata = 0. An in-flight access is abandoned and no done pulse is issued.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE, grant decision at the clock edge:
  - MEM wins if (mem_rd|mem_wr) and (starve_cnt<STARVE_MAX or !if_req).
  - Otherwise IF wins if if_req.
  - Otherwise stay in IDLE.
  - Grant owner, address, wdata and we are latched; go to ISSUE.
- ISSUE: ram_en=1 for exactly this cycle, with ram_addr, ram_we and ram_wdata driven from the latched values. lat_cnt loads MEM_LAT-1. Next state is WAIT.
- WAIT: lat_cnt decrements each cycle. At lat_cnt==0, ram_rdata is captured into the owner's rdata register and the FSM goes to DONE. With MEM_LAT=1, WAIT lasts one cycle.
- DONE: the owner's done signal is high for exactly one cycle; next state is IDLE. Requests are not sampled in DONE, because the requester deasserts at the same edge.
- Latency: a request seen at edge k gives done high in cycle k+MEM_LAT+2. Minimum spacing between accesses is MEM_LAT+3 cycles.
- Writes: mem_rdata holds its previous value; mem_done pulses with the same latency as a read.
- mem_rd and mem_wr both high: treated as a write (ram_we=1). Flagged by an assertion in simulation.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each MEM grant made while if_req is high.
  - Clears on each IF grant, and whenever if_req is low in IDLE.
- Stall outputs (combinational):
  - stall_pipe = (mem_rd|mem_wr) & !mem_done.
  - stall_if = (if_req & !if_done) | stall_pipe.
- Only one owner at a time. if_done and mem_done are never high in the same cycle.
- ram_addr and ram_wdata hold their last values outside ISSUE; ram_we=0 outside ISSUE.
- Request dropped by a requester mid-access (protocol violation): the access completes and done still pulses.

Decomposition:
- Shared package pipe_pkg holds:
  - The arbiter state enum (IDLE, ISSUE, WAIT, DONE).
  - The owner encoding (OWN_IF=0, OWN_MEM=1).
  - Latency width constant LAT_W=4.
- One natural sub-module: arb_starve_counter (saturating counter with clear, width from STARVE_MAX). Everything else stays in mem_port_arbiter.

Test Plan:
- Reset, then if_req=1, if_addr=0x40, RAM returns 0x8C220004, MEM_LAT=2 -> ram_en high exactly once with addr 0x40 and we=0; if_done in cycle k+4; if_rdata=0x8C220004; stall_if high from cycle k until if_done.
- mem_wr=1, addr=0x100, wdata=0xDEADBEEF -> one ram_en cycle with ram_we=1 and ram_wdata=0xDEADBEEF; mem_done pulses one cycle; mem_rdata unchanged; stall_pipe low in the cycle after mem_done.
- if_req and mem_rd both held high continuously, STARVE_MAX=3 -> grant order MEM, MEM, MEM, IF, MEM, MEM, MEM, IF; no cycle with both done signals high.
- mem_rd pulses back-to-back with if_req=0 -> starve_cnt stays 0; accesses spaced exactly MEM_LAT+3=5 cycles.
- rst asserted asynchronously during WAIT of a load -> all outputs 0 immediately; no mem_done; after release, a re-issued request completes normally.
- MEM_LAT=1 build, single fetch -> if_done in cycle k+3 with correct data.
